// File: rtl/pll_serial_loader.sv
`default_nettype none
// pll_serial_loader: host-written word file shifted out MSB-first on sdo/sclk/csb, one csb frame per word.
// Optional PLL_LOADER_AUTOSTART_EN issues one sequence on the first clk after reset release. Rev 1.0
module pll_serial_loader #(
  parameter int WORD_W    = 24,
  parameter int NUM_WORDS = 3,
  parameter int ADDR_W    = 2,
  parameter int CLK_DIV   = 1,
  parameter int GAP_HP    = 2,
  parameter logic [NUM_WORDS*WORD_W-1:0] INIT_WORDS = {24'h409C22, 24'h8FF980, 24'h3000C9}
) (
  input  logic              clk,
  input  logic              rset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              sdo,
  output logic              sclk,
  output logic              csb
);

  localparam int HP_MAX = (2 * WORD_W > GAP_HP) ? 2 * WORD_W : GAP_HP;
  localparam int HP_W   = $clog2(HP_MAX + 1);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [ADDR_W:0]   NUM_WORDS_C = NUM_WORDS[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST_WORD   = ADDR_W'(NUM_WORDS - 1);
  localparam logic [HP_W-1:0]   SHIFT_LAST  = HP_W'(2 * WORD_W - 1);
  localparam logic [HP_W-1:0]   GAP_LAST    = HP_W'(GAP_HP - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t              state, state_n;
  logic [DIV_W-1:0]    div_cnt, div_n;
  logic [HP_W-1:0]     hp_cnt, hp_n;
  logic [ADDR_W-1:0]   word_idx, word_n;
  logic [WORD_W-1:0]   shreg, shreg_n;
  logic                sclk_n, csb_n, busy_n, done_n;
  logic [WORD_W-1:0]   regs [NUM_WORDS];
  logic                start_eff, write_ok, half_end;
  logic [WORD_W-1:0]   first_word, next_word;

`ifdef PLL_LOADER_AUTOSTART_EN
  logic auto_pend;
  always_ff @(posedge clk or negedge rset_n) begin
    if (!rset_n) auto_pend <= 1'b1;
    else         auto_pend <= 1'b0;
  end
  assign start_eff = start | auto_pend;
`else
  assign start_eff = start;
`endif

  assign write_ok = (state == IDLE) && wr_en && ({1'b0, wr_addr} < NUM_WORDS_C);
  // A write in the same cycle as start must be the value that goes out.
  assign first_word = (write_ok && wr_addr == '0) ? wr_data : regs[0];
  assign next_word  = regs[word_idx + ADDR_W'(1)];
  assign half_end   = (div_cnt == DIV_LAST);
  assign sdo        = shreg[WORD_W-1];

  always_ff @(posedge clk or negedge rset_n) begin
    if (!rset_n) begin
      for (int i = 0; i < NUM_WORDS; i++) regs[i] <= INIT_WORDS[i*WORD_W +: WORD_W];
    end else if (write_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rset_n) begin
    if (!rset_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      hp_cnt   <= '0;
      word_idx <= '0;
      shreg    <= '0;
      sclk     <= 1'b0;
      csb      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      div_cnt  <= div_n;
      hp_cnt   <= hp_n;
      word_idx <= word_n;
      shreg    <= shreg_n;
      sclk     <= sclk_n;
      csb      <= csb_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    hp_n    = hp_cnt;
    word_n  = word_idx;
    shreg_n = shreg;
    sclk_n  = sclk;
    csb_n   = csb;
    done_n  = 1'b0;

    if (state == IDLE) begin
      div_n   = '0;
      hp_n    = '0;
      sclk_n  = 1'b0;
      csb_n   = 1'b1;
      shreg_n = '0;
      if (start_eff) begin
        state_n = SETUP;
        word_n  = '0;
        shreg_n = first_word;
        csb_n   = 1'b0;
      end
    end else begin
      div_n = half_end ? '0 : div_cnt + DIV_W'(1);
      if (half_end) begin
        unique case (state)
          SETUP: begin
            state_n = SHIFT;
            hp_n    = '0;
            sclk_n  = 1'b1;
          end
          SHIFT: begin
            if (hp_cnt == SHIFT_LAST) begin
              state_n = HOLD;
              hp_n    = '0;
              sclk_n  = 1'b0;
            end else begin
              hp_n   = hp_cnt + HP_W'(1);
              sclk_n = ~sclk;
              // Even half-periods are the high half; leaving one is the falling edge.
              if (!hp_cnt[0]) shreg_n = {shreg[WORD_W-2:0], 1'b0};
            end
          end
          HOLD: begin
            state_n = GAP;
            hp_n    = '0;
            csb_n   = 1'b1;
            shreg_n = '0;
          end
          GAP: begin
            if (hp_cnt == GAP_LAST) begin
              hp_n = '0;
              if (word_idx != LAST_WORD) begin
                state_n = SETUP;
                word_n  = word_idx + ADDR_W'(1);
                shreg_n = next_word;
                csb_n   = 1'b0;
              end else begin
                state_n = IDLE;
                done_n  = 1'b1;
              end
            end else begin
              hp_n = hp_cnt + HP_W'(1);
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
    busy_n = (state_n != IDLE);
  end

endmodule
`default_nettype wire
